// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl
//   Phase sequencer for a two-road intersection with a pedestrian crossing.
//   A Moore state machine steps through the light phases. Each timed phase
//   lasts a fixed number of ticks of the external `tick` enable. The
//   controller leaves main-green only when there is demand: a side-road car
//   or a latched pedestrian request.
//
// Ports
//   clk        system clock, rising edge
//   rst_a      asynchronous reset, active low
//   tick       one-cycle timing enable from the prescaler
//   side_car   side-road vehicle present (level)
//   ped_req    pedestrian button (pulse or level), latched every cycle
//   main_light {red,yellow,green} for the main road, one-hot
//   side_light {red,yellow,green} for the side road, one-hot
//   walk       pedestrian WALK lamp
//   ped_ack    high for the first cycle spent in PED_WALK
//   phase      current state code, for debug and display
module traffic_phase_ctrl #(
    parameter int TW         = 8,
    parameter int T_MAIN_MIN = 8,
    parameter int T_YELLOW   = 3,
    parameter int T_ALLRED   = 1,
    parameter int T_SIDE     = 6,
    parameter int T_WALK     = 5
) (
    input  logic       clk,
    input  logic       rst_a,
    input  logic       tick,
    input  logic       side_car,
    input  logic       ped_req,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic       walk,
    output logic       ped_ack,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        MAIN_GREEN  = 3'd0,
        MAIN_YELLOW = 3'd1,
        ALL_RED_1   = 3'd2,
        SIDE_GREEN  = 3'd3,
        SIDE_YELLOW = 3'd4,
        ALL_RED_2   = 3'd5,
        PED_WALK    = 3'd6
    } state_t;

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    state_t          state, state_next;
    logic [TW-1:0]   timer, timer_next;
    logic            ped_pending;
    logic            expired;
    logic            enter;
    logic            enter_walk;

    // Timer reload value is one less than the phase length, so the phase
    // expires on the tick that finds the timer already at zero.
    function automatic logic [TW-1:0] load_value(input state_t s);
        case (s)
            MAIN_GREEN:  load_value = TW'(T_MAIN_MIN - 1);
            MAIN_YELLOW: load_value = TW'(T_YELLOW - 1);
            SIDE_YELLOW: load_value = TW'(T_YELLOW - 1);
            SIDE_GREEN:  load_value = TW'(T_SIDE - 1);
            PED_WALK:    load_value = TW'(T_WALK - 1);
            default:     load_value = TW'(T_ALLRED - 1);
        endcase
    endfunction

    always_comb begin
        state_next = state;
        timer_next = timer;
        enter      = 1'b0;
        expired    = tick && (timer == '0);

        case (state)
            MAIN_GREEN: begin
                // Without demand the state holds with the timer parked at 0,
                // so the first tick that sees demand moves on at once.
                if (expired && (side_car || ped_pending)) begin
                    state_next = MAIN_YELLOW;
                    enter      = 1'b1;
                end
            end
            MAIN_YELLOW: begin
                if (expired) begin
                    state_next = ALL_RED_1;
                    enter      = 1'b1;
                end
            end
            ALL_RED_1: begin
                if (expired) begin
                    enter = 1'b1;
                    if (ped_pending)   state_next = PED_WALK;
                    else if (side_car) state_next = SIDE_GREEN;
                    else               state_next = MAIN_GREEN;
                end
            end
            SIDE_GREEN: begin
                if (expired) begin
                    state_next = SIDE_YELLOW;
                    enter      = 1'b1;
                end
            end
            SIDE_YELLOW: begin
                if (expired) begin
                    state_next = ALL_RED_2;
                    enter      = 1'b1;
                end
            end
            ALL_RED_2: begin
                if (expired) begin
                    state_next = MAIN_GREEN;
                    enter      = 1'b1;
                end
            end
            PED_WALK: begin
                if (expired) begin
                    state_next = side_car ? SIDE_GREEN : ALL_RED_2;
                    enter      = 1'b1;
                end
            end
            default: begin
                // Illegal code: recover to all-red on the next clock.
                state_next = ALL_RED_2;
                enter      = 1'b1;
            end
        endcase

        if (enter)
            timer_next = load_value(state_next);
        else if (tick && (timer != '0))
            timer_next = timer - 1'b1;

        enter_walk = enter && (state_next == PED_WALK);
    end

    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            state       <= ALL_RED_2;
            timer       <= TW'(T_ALLRED - 1);
            ped_pending <= 1'b0;
            ped_ack     <= 1'b0;
        end else begin
            state       <= state_next;
            timer       <= timer_next;
            // A request on the entry clock wins over the clear and queues
            // another walk.
            ped_pending <= ped_req || (ped_pending && !enter_walk);
            ped_ack     <= enter_walk;
        end
    end

    // Moore outputs, decoded from the state register only.
    always_comb begin
        main_light = LAMP_RED;
        side_light = LAMP_RED;
        walk       = 1'b0;
        case (state)
            MAIN_GREEN:  main_light = LAMP_GREEN;
            MAIN_YELLOW: main_light = LAMP_YELLOW;
            SIDE_GREEN:  side_light = LAMP_GREEN;
            SIDE_YELLOW: side_light = LAMP_YELLOW;
            PED_WALK:    walk       = 1'b1;
            default:     ;
        endcase
    end

    assign phase = state;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
module tb_traffic_phase_ctrl;

    logic       clk = 1'b0;
    logic       rst_a;
    logic       tick;
    logic       side_car;
    logic       ped_req;
    logic [2:0] main_light;
    logic [2:0] side_light;
    logic       walk;
    logic       ped_ack;
    logic [2:0] phase;

    int errors = 0;
    int checks = 0;

    traffic_phase_ctrl dut (
        .clk        (clk),
        .rst_a      (rst_a),
        .tick       (tick),
        .side_car   (side_car),
        .ped_req    (ped_req),
        .main_light (main_light),
        .side_light (side_light),
        .walk       (walk),
        .ped_ack    (ped_ack),
        .phase      (phase)
    );

    always #5 clk = ~clk;

    // Reference model: phase number, ticks remaining in the phase (including
    // the current one), pending pedestrian flag, ack flag.
    int dur [7] = '{8, 3, 1, 6, 3, 1, 5};
    int m_state;
    int m_left;
    bit m_pend;
    bit m_ack;

    function automatic int route(int s, bit car, bit pend);
        case (s)
            0: return (car || pend) ? 1 : 0;
            1: return 2;
            2: return pend ? 6 : (car ? 3 : 0);
            3: return 4;
            4: return 5;
            6: return car ? 3 : 5;
            default: return 0;
        endcase
    endfunction

    function automatic logic [10:0] expv();
        logic [2:0] ml, sl;
        ml = (m_state == 0) ? 3'b001 : (m_state == 1) ? 3'b010 : 3'b100;
        sl = (m_state == 3) ? 3'b001 : (m_state == 4) ? 3'b010 : 3'b100;
        return {3'(m_state), ml, sl, (m_state == 6), m_ack};
    endfunction

    function automatic logic [10:0] got();
        return {phase, main_light, side_light, walk, ped_ack};
    endfunction

    task automatic model_reset();
        m_state = 5;
        m_left  = 1;
        m_pend  = 0;
        m_ack   = 0;
    endtask

    // One clock: the model consumes the inputs present at the edge, then
    // time moves 1 unit past the edge where outputs are sampled.
    task automatic adv();
        bit exp_now, entered;
        int nxt;
        @(posedge clk);
        exp_now = tick && (m_left == 1);
        entered = 0;
        nxt     = m_state;
        if (exp_now) begin
            nxt = route(m_state, side_car, m_pend);
            entered = !(m_state == 0 && nxt == 0);
        end
        if (entered) m_left = dur[nxt];
        else if (tick && m_left > 1) m_left--;
        m_ack   = entered && (nxt == 6);
        m_pend  = ped_req || (m_pend && !(entered && nxt == 6));
        m_state = nxt;
        #1;
    endtask

    task automatic reset_dut();
        tick = 0; side_car = 0; ped_req = 0;
        rst_a = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_a = 1'b1;
    endtask

    task automatic test_reset();
        tick = 0; side_car = 0; ped_req = 0;
        rst_a = 1'b0;
        model_reset();
        #1;
        checks++;
        if (got() !== 11'b101_100_100_0_0) begin
            errors++;
            $display("FAIL reset_values: got %b expected %b", got(), 11'b101_100_100_0_0);
        end
        @(negedge clk);
        @(negedge clk);
        rst_a = 1'b1;
        tick = 1;
        for (int i = 0; i < 52; i++) begin
            adv();
            checks++;
            if (got() !== expv()) begin
                errors++;
                $display("FAIL idle_main cyc %0d: got %b expected %b", i, got(), expv());
            end
        end
        checks++;
        if (main_light !== 3'b001) begin
            errors++;
            $display("FAIL idle_main_held: main_light %b expected 001", main_light);
        end
    endtask

    task automatic test_side_cycle();
        reset_dut();
        tick = 1; side_car = 1;
        for (int i = 0; i < 70; i++) begin
            adv();
            checks++;
            if (got() !== expv()) begin
                errors++;
                $display("FAIL side_cycle cyc %0d: got %b expected %b", i, got(), expv());
            end
        end
    endtask

    task automatic test_ped();
        int walks = 0, acks = 0;
        reset_dut();
        tick = 1; side_car = 0;
        for (int i = 0; i < 40; i++) begin
            ped_req = (i == 2);
            adv();
            walks += walk;
            acks  += ped_ack;
            checks++;
            if (got() !== expv()) begin
                errors++;
                $display("FAIL ped_walk cyc %0d: got %b expected %b", i, got(), expv());
            end
        end
        ped_req = 0;
        checks++;
        if (walks != 5 || acks != 1) begin
            errors++;
            $display("FAIL ped_counts: walk cycles %0d ack pulses %0d expected 5 and 1", walks, acks);
        end
        checks++;
        if (phase !== 3'd0) begin
            errors++;
            $display("FAIL ped_returns_main: phase %0d expected 0", phase);
        end
    endtask

    task automatic test_back_to_back();
        int q[$];
        int exp_seq [8] = '{0, 1, 2, 6, 3, 4, 5, 0};
        reset_dut();
        tick = 1; side_car = 1; ped_req = 1;
        for (int i = 0; i < 60; i++) begin
            adv();
            if (q.size() == 0 || q[$] != int'(phase)) q.push_back(int'(phase));
            checks++;
            if (got() !== expv()) begin
                errors++;
                $display("FAIL back_to_back cyc %0d: got %b expected %b", i, got(), expv());
            end
        end
        ped_req = 0;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (k >= q.size() || q[k] != exp_seq[k]) begin
                errors++;
                $display("FAIL b2b_order idx %0d: got %0d expected %0d", k,
                         (k < q.size()) ? q[k] : -1, exp_seq[k]);
            end
        end
    endtask

    task automatic test_slow_tick();
        int run_ph[$], run_len[$];
        int cur_ph, cur_len, g_len, y_len;
        reset_dut();
        side_car = 1;
        cur_ph = 5; cur_len = 0;
        for (int k = 0; k < 140; k++) begin
            tick = (k % 4 == 3);
            adv();
            if (int'(phase) == cur_ph) cur_len++;
            else begin
                run_ph.push_back(cur_ph);
                run_len.push_back(cur_len);
                cur_ph = int'(phase);
                cur_len = 1;
            end
            checks++;
            if (got() !== expv()) begin
                errors++;
                $display("FAIL slow_tick cyc %0d: got %b expected %b", k, got(), expv());
            end
        end
        tick = 0;
        g_len = -1; y_len = -1;
        foreach (run_ph[j]) begin
            if (run_ph[j] == 0 && g_len < 0) g_len = run_len[j];
            if (run_ph[j] == 1 && y_len < 0) y_len = run_len[j];
        end
        checks++;
        if (g_len != 32) begin
            errors++;
            $display("FAIL slow_main_len: got %0d cycles expected 32", g_len);
        end
        checks++;
        if (y_len != 12) begin
            errors++;
            $display("FAIL slow_yellow_len: got %0d cycles expected 12", y_len);
        end
    endtask

    task automatic test_async_reset();
        int n = 0;
        reset_dut();
        tick = 1; side_car = 1;
        while (!(m_state == 3 && m_left == 4) && n < 100) begin
            adv();
            n++;
        end
        checks++;
        if (n >= 100 || got() !== expv()) begin
            errors++;
            $display("FAIL async_setup: got %b expected %b after %0d cycles", got(), expv(), n);
        end
        #1;
        rst_a = 1'b0;
        model_reset();
        #1;
        checks++;
        if (got() !== 11'b101_100_100_0_0) begin
            errors++;
            $display("FAIL async_reset_allred: got %b expected %b", got(), 11'b101_100_100_0_0);
        end
        @(negedge clk);
        rst_a = 1'b1;
        side_car = 0;
        for (int i = 0; i < 4; i++) begin
            adv();
            checks++;
            if (got() !== expv()) begin
                errors++;
                $display("FAIL async_recover cyc %0d: got %b expected %b", i, got(), expv());
            end
        end
        checks++;
        if (phase !== 3'd0) begin
            errors++;
            $display("FAIL async_to_main: phase %0d expected 0", phase);
        end
    endtask

    task automatic test_random();
        reset_dut();
        for (int i = 0; i < 3000; i++) begin
            tick     = 1'($urandom_range(0, 1));
            side_car = ($urandom_range(0, 7) < 2);
            ped_req  = ($urandom_range(0, 31) == 0);
            adv();
            checks++;
            if (got() !== expv()) begin
                errors++;
                $display("FAIL random cyc %0d: got %b expected %b", i, got(), expv());
            end
            checks++;
            if (main_light != 3'b100 && side_light != 3'b100) begin
                errors++;
                $display("FAIL lamp_exclusive cyc %0d: main %b side %b expected one road red",
                         i, main_light, side_light);
            end
        end
    endtask

    initial begin
        rst_a = 1'b1; tick = 0; side_car = 0; ped_req = 0;
        #2;
        test_reset();
        test_side_cycle();
        test_ped();
        test_back_to_back();
        test_slow_tick();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
